// File: rtl/everloop_ctrl.sv
// ---------------------------------------------------------------------------
// everloop_ctrl
//   LED-ring controller on the j1 I/O bus. The CPU fills a pixel RAM one byte
//   at a time; a serializer streams the frame as a single-wire NRZ pulse train
//   (WS2812 style), then holds the line low for the latch gap.
//
//   Address map (NB = N_LEDS*BPL):
//     0..NB-1  pixel RAM (byte 0 sent first, MSB first)
//     NB       CTRL   write: bit0 START (one-shot), bit1 AUTO; read {6'b0,AUTO,1'b0}
//     NB+1     STATUS read: {5'b0, pending, done_sticky, busy}
//     above    writes ignored, reads return 0x00
//
//   Ports:
//     clk         system clock
//     rst         asynchronous reset, active low
//     cs/wr/rd    chip select, write strobe, read strobe (strobes qualified by cs)
//     addr        byte address
//     d_in        write data
//     d_out       registered read data (valid the cycle after cs&&rd)
//     led_data    serial pixel stream
//     busy        frame in progress (bits or latch gap)
//     frame_done  one-cycle pulse at the end of each latch gap
//
//   Optional feature macro: EVERLOOP_DBUF_EN
//     Defined   -> two RAM banks; the CPU sees the back bank, the serializer
//                  reads the front bank, and the banks swap in the LOAD cycle
//                  that starts each frame.
//     Undefined -> single bank; CPU writes that land ahead of the serializer
//                  show up in the frame being sent.
// ---------------------------------------------------------------------------
module everloop_ctrl #(
  parameter int N_LEDS = 35,
  parameter int BPL    = 4,
  parameter int ADDR_W = 9,
  parameter int T_BIT  = 62,
  parameter int T0H    = 18,
  parameter int T1H    = 35,
  parameter int T_RST  = 2600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        d_in,
  output logic [7:0]        d_out,
  output logic              led_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int NB = N_LEDS * BPL;
`ifdef EVERLOOP_DBUF_EN
  localparam int N_BANKS = 2;
`else
  localparam int N_BANKS = 1;
`endif
  localparam int MEM_D = NB * N_BANKS;
  localparam int MEM_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;
  localparam int BI_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int T_MAX = (T_BIT > T_RST) ? T_BIT : T_RST;
  localparam int CNT_W = $clog2(T_MAX + 1);

  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(NB);
  localparam logic [ADDR_W-1:0] A_STAT    = ADDR_W'(NB + 1);
  localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(NB - 1);
  localparam logic [CNT_W-1:0]  C_BIT_END = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0]  C_RST_END = CNT_W'(T_RST);
  localparam logic [CNT_W-1:0]  C_T0H     = CNT_W'(T0H);
  localparam logic [CNT_W-1:0]  C_T1H     = CNT_W'(T1H);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BIT, S_LATCH} state_t;

  state_t           state;
  logic [7:0]       mem [MEM_D];
  logic             auto_mode;
  logic             pending;
  logic             done_sticky;
  logic [CNT_W-1:0] tcnt;
  logic [2:0]       bit_cnt;
  logic [BI_W-1:0]  byte_idx;
  logic [7:0]       shift;
  logic [7:0]       prefetch;
  logic             start_req;
  logic             status_rd;
  logic             pix_sel;
  logic [MEM_W-1:0] cpu_idx;
  logic [MEM_W-1:0] load_idx;
  logic [MEM_W-1:0] pf_idx;
`ifdef EVERLOOP_DBUF_EN
  logic             front;
`endif

  // Bus decode and RAM index generation. With two banks, bank b lives at
  // b*NB; the CPU addresses the back bank, and LOAD reads the bank that is
  // about to become the front one (the current back bank).
  always_comb begin
    pix_sel   = (addr < A_CTRL);
    start_req = cs && wr && (addr == A_CTRL) && d_in[0];
    status_rd = cs && rd && (addr == A_STAT);
`ifdef EVERLOOP_DBUF_EN
    cpu_idx   = MEM_W'(addr) + (front ? MEM_W'(0) : MEM_W'(NB));
    load_idx  = front ? MEM_W'(0) : MEM_W'(NB);
    pf_idx    = MEM_W'(byte_idx) + MEM_W'(1) + (front ? MEM_W'(NB) : MEM_W'(0));
`else
    cpu_idx   = MEM_W'(addr);
    load_idx  = '0;
    pf_idx    = MEM_W'(byte_idx) + MEM_W'(1);
`endif
  end

  // Pixel RAM: write port for the CPU only, deliberately not reset.
  always_ff @(posedge clk) begin
    if (cs && wr && pix_sel) mem[cpu_idx] <= d_in;
  end

  // CPU-visible registers: the stored AUTO bit and the registered read mux.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_mode <= 1'b0;
      d_out     <= 8'h00;
    end else begin
      if (cs && wr && (addr == A_CTRL)) auto_mode <= d_in[1];
      if (cs && rd) begin
        if (pix_sel)               d_out <= mem[cpu_idx];
        else if (addr == A_CTRL)   d_out <= {6'b0, auto_mode, 1'b0};
        else if (addr == A_STAT)   d_out <= {5'b0, pending, done_sticky, busy};
        else                       d_out <= 8'h00;
      end
    end
  end

  // Serializer FSM. led_data is registered, so it trails the bit counter by
  // one cycle; this gives the two-cycle START-to-first-rise latency (START
  // edge -> LOAD edge -> first BIT edge drives the line high).
  // The next byte is fetched at the start of bit 7 so the byte boundary has
  // no gap. A START landing on the edge that leaves LATCH folds into the
  // frame that begins there instead of queueing another one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      led_data    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      pending     <= 1'b0;
      done_sticky <= 1'b0;
      tcnt        <= '0;
      bit_cnt     <= 3'd0;
      byte_idx    <= '0;
      shift       <= 8'h00;
      prefetch    <= 8'h00;
`ifdef EVERLOOP_DBUF_EN
      front       <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (status_rd) done_sticky <= 1'b0;
      if (start_req && (state != S_IDLE)) pending <= 1'b1;
      case (state)
        S_IDLE: begin
          led_data <= 1'b0;
          if (start_req) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          led_data <= 1'b0;
          shift    <= mem[load_idx];
          byte_idx <= '0;
          bit_cnt  <= 3'd0;
          tcnt     <= '0;
          state    <= S_BIT;
`ifdef EVERLOOP_DBUF_EN
          front    <= ~front;
`endif
        end
        S_BIT: begin
          led_data <= (tcnt < (shift[7] ? C_T1H : C_T0H));
          if ((bit_cnt == 3'd7) && (tcnt == '0) && (byte_idx != LAST_BYTE))
            prefetch <= mem[pf_idx];
          if (tcnt == C_BIT_END) begin
            tcnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              if (byte_idx == LAST_BYTE) begin
                state <= S_LATCH;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                shift    <= prefetch;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= {shift[6:0], 1'b0};
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_LATCH: begin
          led_data <= 1'b0;
          if (tcnt == C_RST_END) begin
            tcnt        <= '0;
            frame_done  <= 1'b1;
            done_sticky <= 1'b1;
            if (pending || auto_mode || start_req) begin
              state   <= S_LOAD;
              pending <= 1'b0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_everloop_ctrl.sv
// ---------------------------------------------------------------------------
// tb_everloop_ctrl
//   Self-checking bench for everloop_ctrl with a one-LED, four-byte ring.
//   A line monitor turns led_data into a list of high-pulse widths and
//   rise/frame_done times; a byte-level model of the pixel RAM (front/back
//   copies when EVERLOOP_DBUF_EN is defined) predicts the width of every bit.
// ---------------------------------------------------------------------------
module tb_everloop_ctrl;

  localparam int N_LEDS = 1;
  localparam int BPL    = 4;
  localparam int ADDR_W = 9;
  localparam int T_BIT  = 62;
  localparam int T0H    = 18;
  localparam int T1H    = 35;
  localparam int T_RST  = 2600;
  localparam int NB     = N_LEDS * BPL;
  localparam int NBITS  = NB * 8;
  localparam int FRAME  = NBITS * T_BIT + T_RST;
  localparam int A_CTRL = NB;
  localparam int A_STAT = NB + 1;

  logic              clk  = 1'b0;
  logic              rst  = 1'b0;
  logic              cs   = 1'b0;
  logic              wr   = 1'b0;
  logic              rd   = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [7:0]        d_in = 8'h00;
  logic [7:0]        d_out;
  logic              led_data;
  logic              busy;
  logic              frame_done;

  typedef struct {
    logic       do_wr;
    int         a;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[15];

  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc_cnt = 0;
  int hi_cnt  = 0;
  logic prev_led = 1'b0;
  int widths[$];
  int rises[$];
  int dones[$];
  int done_busy[$];
  int exp_w[$];
  logic [7:0] ram_back[NB];
  logic [7:0] ram_front[NB];

  everloop_ctrl #(
    .N_LEDS(N_LEDS), .BPL(BPL), .ADDR_W(ADDR_W),
    .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RST(T_RST)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
    .d_in(d_in), .d_out(d_out), .led_data(led_data), .busy(busy),
    .frame_done(frame_done)
  );

  // 10-unit clock; inputs change and outputs are sampled around the falling edge.
  always #5 clk = ~clk;

  // Rising-edge counter used as the time base for latency checks.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Line monitor: records each high pulse width, each rise time and each
  // frame_done time (with busy at that moment).
  always @(negedge clk) begin
    if (led_data) begin
      hi_cnt <= hi_cnt + 1;
      if (!prev_led) rises.push_back(cyc_cnt);
    end else if (prev_led) begin
      widths.push_back(hi_cnt);
      hi_cnt <= 0;
    end
    prev_led <= led_data;
    if (frame_done) begin
      dones.push_back(cyc_cnt);
      done_busy.push_back(int'(busy));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input int a, input logic [7:0] d);
    addr = ADDR_W'(a);
    d_in = d;
    cs   = 1'b1;
    wr   = 1'b1;
    tick();
    cs   = 1'b0;
    wr   = 1'b0;
    if (a < NB) ram_back[a] = d;
  endtask

  task automatic bus_read(input int a, output logic [7:0] d);
    addr = ADDR_W'(a);
    cs   = 1'b1;
    rd   = 1'b1;
    tick();
    cs   = 1'b0;
    rd   = 1'b0;
    d    = d_out;
  endtask

  // One frame begins: the serializer's view becomes the back copy, then the
  // expected high width of each bit follows from the bytes, MSB first.
  task automatic model_frame();
`ifdef EVERLOOP_DBUF_EN
    logic [7:0] tmp[NB];
    tmp       = ram_front;
    ram_front = ram_back;
    ram_back  = tmp;
`else
    ram_front = ram_back;
`endif
    for (int i = 0; i < NBITS; i++)
      exp_w.push_back(ram_front[i / 8][7 - (i % 8)] ? T1H : T0H);
  endtask

  task automatic clear_mon();
    widths.delete();
    rises.delete();
    dones.delete();
    done_busy.delete();
    exp_w.delete();
  endtask

  task automatic check_widths();
    checkOutput("bit_count", widths.size(), exp_w.size());
    for (int i = 0; i < widths.size() && i < exp_w.size(); i++)
      checkOutput($sformatf("bit%0d_high", i), widths[i], exp_w[i]);
  endtask

  task automatic wait_dones(input int n, input int bound);
    for (int i = 0; i < bound && dones.size() < n; i++) tick();
    checkOutput("frames_done", dones.size(), n);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [7:0] r;
    if (v.do_wr) begin
      bus_write(v.a, v.wd);
    end else begin
      bus_read(v.a, r);
      checkOutput($sformatf("read_addr%0d", v.a), r, v.exp);
    end
  endtask

  initial begin
    logic [7:0] rv;
    logic [5:0] junk;
    int s;
    int b;

    vecs[0]  = '{1'b1, 2,      8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 2,      8'h00, 8'hA5};
    vecs[2]  = '{1'b1, 0,      8'h3C, 8'h00};
    vecs[3]  = '{1'b0, 0,      8'h00, 8'h3C};
    vecs[4]  = '{1'b0, NB + 5, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, A_CTRL, 8'h02, 8'h00};
    vecs[6]  = '{1'b0, A_CTRL, 8'h00, 8'h02};
    vecs[7]  = '{1'b1, A_CTRL, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, A_CTRL, 8'h00, 8'h00};
    vecs[9]  = '{1'b0, A_STAT, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 496,    8'h77, 8'h00};
    vecs[11] = '{1'b0, 496,    8'h00, 8'h00};
    vecs[12] = '{1'b1, A_STAT, 8'hFF, 8'h00};
    vecs[13] = '{1'b0, A_STAT, 8'h00, 8'h00};
    vecs[14] = '{1'b0, 2,      8'h00, 8'hA5};

    // Reset values.
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checkOutput("reset_led", led_data, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    checkOutput("reset_d_out", d_out, 0);

    // Register and readback vectors.
    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

    // Reference frame 80 00 00 01 with latency and length checks.
    clear_mon();
    bus_write(0, 8'h80);
    bus_write(1, 8'h00);
    bus_write(2, 8'h00);
    bus_write(3, 8'h01);
    bus_write(A_CTRL, 8'h01);
    s = cyc_cnt;
    model_frame();
    checkOutput("busy_after_start", busy, 1);
    wait_dones(1, FRAME + 100);
    check_widths();
    if (rises.size() > 0) checkOutput("first_rise_latency", rises[0] - s, 2);
    if (rises.size() > 0 && dones.size() > 0)
      checkOutput("frame_length", dones[0] - rises[0], FRAME);
    if (done_busy.size() > 0) checkOutput("busy_at_done", done_busy[0], 0);
    bus_read(A_STAT, rv);
    checkOutput("status_sticky_set", rv, 8'h02);
    bus_read(A_STAT, rv);
    checkOutput("status_sticky_clear", rv, 8'h00);

    // Random pixel frames against the byte model.
    for (int r = 0; r < 3; r++) begin
      clear_mon();
      for (int k = 0; k < NB; k++) bus_write(k, 8'($urandom_range(0, 255)));
      b = $urandom_range(0, NB - 1);
      bus_read(b, rv);
      checkOutput("random_readback", rv, ram_back[b]);
      junk = 6'($urandom);
      bus_write(A_CTRL, {junk[5:1], 1'b0, 2'b01});
      model_frame();
      wait_dones(1, FRAME + 100);
      check_widths();
      if (rises.size() > 0 && dones.size() > 0)
        checkOutput("random_frame_length", dones[0] - rises[0], FRAME);
    end
    bus_read(A_STAT, rv);
    checkOutput("status_after_random", rv, 8'h02);

    // Two STARTs inside one frame queue exactly one extra frame.
    clear_mon();
    bus_write(A_CTRL, 8'h01);
    model_frame();
    repeat (500) tick();
    bus_write(A_CTRL, 8'h01);
    model_frame();
    repeat (50) tick();
    bus_read(A_STAT, rv);
    checkOutput("status_pending", rv, 8'h05);
    wait_dones(2, 2 * FRAME + 200);
    repeat (200) tick();
    checkOutput("queued_frames_only", dones.size(), 2);
    checkOutput("busy_after_queue", busy, 0);
    if (dones.size() > 0 && rises.size() > NBITS)
      checkOutput("queued_gap", rises[NBITS] - dones[0], 2);
    check_widths();

    // AUTO refresh, cleared during the third frame.
    bus_read(A_STAT, rv);
    checkOutput("status_before_auto", rv, 8'h02);
    clear_mon();
    bus_write(A_CTRL, 8'h03);
    model_frame();
    model_frame();
    model_frame();
    wait_dones(2, 2 * FRAME + 200);
    repeat (1000) tick();
    bus_write(A_CTRL, 8'h00);
    bus_read(A_CTRL, rv);
    checkOutput("auto_cleared", rv, 8'h00);
    checkOutput("busy_mid_third", busy, 1);
    wait_dones(3, FRAME + 200);
    repeat (300) tick();
    checkOutput("auto_stop_frames", dones.size(), 3);
    checkOutput("auto_stop_busy", busy, 0);
    if (dones.size() > 1 && rises.size() > 2 * NBITS) begin
      checkOutput("auto_gap1", rises[NBITS] - dones[0], 2);
      checkOutput("auto_gap2", rises[2 * NBITS] - dones[1], 2);
    end
    check_widths();
    bus_read(A_STAT, rv);
    checkOutput("auto_sticky_set", rv, 8'h02);
    bus_read(A_STAT, rv);
    checkOutput("auto_sticky_clear", rv, 8'h00);

    // CPU write during a frame.
    clear_mon();
    for (int k = 0; k < NB; k++) bus_write(k, 8'h00);
    bus_write(A_CTRL, 8'h01);
`ifdef EVERLOOP_DBUF_EN
    model_frame();
    repeat (300) tick();
    bus_write(0, 8'hFF);
    wait_dones(1, FRAME + 200);
    bus_write(A_CTRL, 8'h01);
    model_frame();
    wait_dones(2, FRAME + 200);
`else
    repeat (300) tick();
    bus_write(3, 8'hFF);
    model_frame();
    wait_dones(1, FRAME + 200);
`endif
    check_widths();

    // Reset while the line is high.
    bus_write(A_CTRL, 8'h03);
    for (int i = 0; i < 100 && !led_data; i++) tick();
    checkOutput("led_high_before_reset", led_data, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("led_async_reset", led_data, 0);
    checkOutput("busy_async_reset", busy, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    bus_read(A_CTRL, rv);
    checkOutput("ctrl_after_reset", rv, 8'h00);
    bus_read(A_STAT, rv);
    checkOutput("status_after_reset", rv, 8'h00);
    repeat (100) tick();
    checkOutput("idle_busy_after_reset", busy, 0);
    checkOutput("idle_led_after_reset", led_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
